recorder_time_counter: RTL

//  Elapsed-time engine for the sound recorder. Derives a 1 s tick from the system clock.

---
 rtl/recorder_time_counter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/recorder_time_counter.sv
// Elapsed-time engine for the sound recorder: 1 s prescaler, record/play timing,
// and stored take length. All outputs are registered.
module recorder_time_counter #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned MAX_SEC = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rec_btn,
    input  logic       play_btn,
    input  logic       stop_btn,
    output logic [6:0] TIME,
    output logic [6:0] rec_len,
    output logic [1:0] state,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [6:0]    MAX_T    = 7'(MAX_SEC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    time_q, time_d;
    logic [6:0]    rec_len_q, rec_len_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          sec_tick;
    logic [6:0]    time_inc;

    assign sec_tick = (pre_q == PRE_LAST);
    assign time_inc = time_q + 7'd1;

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        rec_len_d = rec_len_q;
        pre_d     = pre_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                pre_d = '0;
                // A stop pulse outranks rec/play even though it has no effect here.
                if (!stop_btn) begin
                    if (rec_btn) begin
                        state_d = RECORD;
                        time_d  = '0;
                    end else if (play_btn && (rec_len_q != 7'd0)) begin
                        state_d = PLAY;
                        time_d  = '0;
                    end
                end
            end
            RECORD: begin
                if (stop_btn) begin
                    rec_len_d = time_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                    pre_d     = '0;
                end else if (sec_tick) begin
                    time_d = time_inc;
                    pre_d  = '0;
                    if (time_inc == MAX_T) begin
                        rec_len_d = MAX_T;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            PLAY: begin
                if (stop_btn) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    pre_d   = '0;
                end else if (sec_tick) begin
                    time_d = time_inc;
                    pre_d  = '0;
                    if (time_inc == rec_len_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pre_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            time_q    <= '0;
            rec_len_q <= '0;
            pre_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            rec_len_q <= rec_len_d;
            pre_q     <= pre_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign TIME    = time_q;
    assign rec_len = rec_len_q;
    assign state   = state_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
